// File: rtl/item_spawner_if.sv
// item_spawner_if: head/tick in from the movement controller,
// item positions and event pulses out to renderer and score logic.
interface item_spawner_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           tick;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [X_W-1:0] apple_x;
    logic [Y_W-1:0] apple_y;
    logic           apple_valid;
    logic [X_W-1:0] poison_x;
    logic [Y_W-1:0] poison_y;
    logic           poison_valid;
    logic           add_cube;
    logic           hit_poison;
    logic           busy;

    modport master (
        output tick, head_x, head_y,
        input  apple_x, apple_y, apple_valid,
        input  poison_x, poison_y, poison_valid,
        input  add_cube, hit_poison, busy
    );

    modport slave (
        input  tick, head_x, head_y,
        output apple_x, apple_y, apple_valid,
        output poison_x, poison_y, poison_valid,
        output add_cube, hit_poison, busy
    );
endinterface

// File: rtl/item_spawner.sv
// item_spawner: apple/poison tracking, eat detection and
// LFSR rejection-sampled respawn on the snake grid.
module item_spawner #(
    parameter int          GRID_W      = 40,
    parameter int          GRID_H      = 30,
    parameter int          X_W         = 6,
    parameter int          Y_W         = 5,
    parameter int          BORDER      = 1,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          POISON_LIFE = 256,
    parameter int          APPLE0_X    = 24,
    parameter int          APPLE0_Y    = 10,
    parameter int          POISON0_X   = 10,
    parameter int          POISON0_Y   = 20
) (
    input logic         clk,
    input logic         rst_n,
    item_spawner_if.slave bus
);
    localparam int LW = (POISON_LIFE < 2) ? 1
                      : $clog2(POISON_LIFE + 1);
    localparam logic [LW-1:0] LIFE0 = LW'(POISON_LIFE);

    typedef enum logic [1:0] {
        IDLE,
        SPAWN_APPLE,
        SPAWN_POISON
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [15:0]    lfsr;
    logic [LW-1:0]  life;
    logic           apple_pend;
    logic           poison_pend;
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic           in_x;
    logic           in_y;
    logic           on_head;
    logic           ok_apple;
    logic           ok_poison;
    logic           eat_apple;
    logic           eat_poison;
    logic           expire;
    logic           place_apple;
    logic           place_poison;

    assign cand_x = lfsr[X_W-1:0];
    assign cand_y = lfsr[15:16-Y_W];

    assign in_x = (int'(cand_x) >= BORDER) &&
                  (int'(cand_x) <= GRID_W - 1 - BORDER);
    assign in_y = (int'(cand_y) >= BORDER) &&
                  (int'(cand_y) <= GRID_H - 1 - BORDER);
    assign on_head = (cand_x == bus.head_x) &&
                     (cand_y == bus.head_y);

    assign ok_apple = in_x && in_y && !on_head &&
                      !(bus.poison_valid &&
                        cand_x == bus.poison_x &&
                        cand_y == bus.poison_y);
    assign ok_poison = in_x && in_y && !on_head &&
                       !(bus.apple_valid &&
                         cand_x == bus.apple_x &&
                         cand_y == bus.apple_y);

    assign eat_apple = bus.apple_valid &&
                       bus.head_x == bus.apple_x &&
                       bus.head_y == bus.apple_y;
    assign eat_poison = bus.poison_valid &&
                        bus.head_x == bus.poison_x &&
                        bus.head_y == bus.poison_y;

    // POISON_LIFE of zero means the poison never expires
    assign expire = (POISON_LIFE != 0) && bus.tick &&
                    bus.poison_valid && (life == LW'(1));

    assign bus.busy = apple_pend | poison_pend |
                      (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        place_apple  = 1'b0;
        place_poison = 1'b0;
        unique case (state)
            IDLE: begin
                if (apple_pend)       state_nx = SPAWN_APPLE;
                else if (poison_pend) state_nx = SPAWN_POISON;
            end
            SPAWN_APPLE: begin
                if (ok_apple) begin
                    place_apple = 1'b1;
                    state_nx    = IDLE;
                end
            end
            SPAWN_POISON: begin
                if (ok_poison) begin
                    place_poison = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr             <= SEED;
            life             <= LIFE0;
            apple_pend       <= 1'b0;
            poison_pend      <= 1'b0;
            bus.apple_x      <= X_W'(APPLE0_X);
            bus.apple_y      <= Y_W'(APPLE0_Y);
            bus.apple_valid  <= 1'b1;
            bus.poison_x     <= X_W'(POISON0_X);
            bus.poison_y     <= Y_W'(POISON0_Y);
            bus.poison_valid <= 1'b1;
            bus.add_cube     <= 1'b0;
            bus.hit_poison   <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^
                    (lfsr[0] ? 16'hB400 : 16'h0000);
            bus.add_cube   <= eat_apple;
            bus.hit_poison <= eat_poison;

            if (eat_apple) begin
                bus.apple_valid <= 1'b0;
                apple_pend      <= 1'b1;
            end else if (place_apple) begin
                bus.apple_x     <= cand_x;
                bus.apple_y     <= cand_y;
                bus.apple_valid <= 1'b1;
                apple_pend      <= 1'b0;
            end

            if (eat_poison || expire) begin
                bus.poison_valid <= 1'b0;
                poison_pend      <= 1'b1;
            end else if (place_poison) begin
                bus.poison_x     <= cand_x;
                bus.poison_y     <= cand_y;
                bus.poison_valid <= 1'b1;
                poison_pend      <= 1'b0;
            end

            if (place_poison)
                life <= LIFE0;
            else if ((POISON_LIFE != 0) && bus.tick &&
                     bus.poison_valid)
                life <= life - LW'(1);
        end
    end
endmodule

// File: tb/tb_item_spawner.sv
// tb_item_spawner: directed scenarios plus random play,
// compared every cycle against a transaction-level model.
module tb_item_spawner;
    localparam int LIFE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    item_spawner_if #(.X_W(6), .Y_W(5)) bus();

    item_spawner #(.POISON_LIFE(LIFE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_add = 0;
    int n_hit = 0;
    int a_rise = -1;
    int p_rise = -1;

    // reference model: items, outstanding respawn requests, LFSR
    logic [15:0] m_lfsr;
    logic [5:0]  m_ax, m_px;
    logic [4:0]  m_ay, m_py;
    bit          m_av, m_pv, m_add, m_hit;
    bit          m_want_a, m_want_p;
    int          m_job;
    int          m_life;

    logic [5:0] pre_ax, pre_px, pre_hx;
    logic [4:0] pre_ay, pre_py, pre_hy;
    bit         pre_av, pre_pv;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(
        input logic [5:0] x, input logic [4:0] y,
        input logic [5:0] hx, input logic [4:0] hy,
        input bit ov, input logic [5:0] ox,
        input logic [4:0] oy);
        return x >= 1 && x <= 38 && y >= 1 && y <= 28 &&
               !(x == hx && y == hy) &&
               !(ov && x == ox && y == oy);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_ax = 6'd24; m_ay = 5'd10; m_av = 1;
        m_px = 6'd10; m_py = 5'd20; m_pv = 1;
        m_add = 0; m_hit = 0;
        m_want_a = 0; m_want_p = 0;
        m_job = 0; m_life = LIFE;
    endtask

    task automatic model_step(input bit t,
                              input logic [5:0] hx,
                              input logic [4:0] hy);
        logic [5:0] cx;
        logic [4:0] cy;
        bit got_a, got_p, gone, put_a, put_p;
        cx = m_lfsr[5:0];
        cy = m_lfsr[15:11];
        got_a = m_av && hx == m_ax && hy == m_ay;
        got_p = m_pv && hx == m_px && hy == m_py;
        gone = t && m_pv && m_life == 1;
        put_a = m_job == 1 &&
                legal(cx, cy, hx, hy, m_pv, m_px, m_py);
        put_p = m_job == 2 &&
                legal(cx, cy, hx, hy, m_av, m_ax, m_ay);
        if (t && m_pv) m_life--;
        if (m_job == 0)
            m_job = m_want_a ? 1 : (m_want_p ? 2 : 0);
        else if (put_a || put_p)
            m_job = 0;
        if (got_a) begin
            m_av = 0; m_want_a = 1;
        end
        if (put_a) begin
            m_ax = cx; m_ay = cy; m_av = 1; m_want_a = 0;
        end
        if (got_p || gone) begin
            m_pv = 0; m_want_p = 1;
        end
        if (put_p) begin
            m_px = cx; m_py = cy; m_pv = 1; m_want_p = 0;
            m_life = LIFE;
        end
        m_add = got_a;
        m_hit = got_p;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^
                 (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    function automatic logic [26:0] dut_vec();
        return {bus.apple_x, bus.apple_y, bus.apple_valid,
                bus.poison_x, bus.poison_y, bus.poison_valid,
                bus.add_cube, bus.hit_poison, bus.busy};
    endfunction

    function automatic logic [26:0] mod_vec();
        bit b;
        b = m_want_a || m_want_p || m_job != 0;
        return {m_ax, m_ay, m_av, m_px, m_py, m_pv,
                m_add, m_hit, b};
    endfunction

    task automatic cycle(input bit t, input int hx,
                         input int hy, input bit r);
        @(negedge clk);
        bus.tick = t;
        bus.head_x = 6'(hx);
        bus.head_y = 5'(hy);
        rst_n = r;
        pre_av = bus.apple_valid; pre_pv = bus.poison_valid;
        pre_ax = bus.apple_x; pre_ay = bus.apple_y;
        pre_px = bus.poison_x; pre_py = bus.poison_y;
        pre_hx = 6'(hx); pre_hy = 5'(hy);
        if (!r) model_reset();
        else    model_step(t, 6'(hx), 5'(hy));
        @(posedge clk);
        #1;
        cyc++;
        check("outs", 32'(dut_vec()), 32'(mod_vec()));
        if (r && !pre_av && bus.apple_valid) begin
            check("apple_legal",
                  32'(legal(bus.apple_x, bus.apple_y,
                            pre_hx, pre_hy, pre_pv,
                            pre_px, pre_py)), 1);
            a_rise = cyc;
        end
        if (r && !pre_pv && bus.poison_valid) begin
            check("poison_legal",
                  32'(legal(bus.poison_x, bus.poison_y,
                            pre_hx, pre_hy, pre_av,
                            pre_ax, pre_ay)), 1);
            p_rise = cyc;
        end
        if (bus.add_cube)   n_add++;
        if (bus.hit_poison) n_hit++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_apple"},
              32'({bus.apple_x, bus.apple_y, bus.apple_valid}),
              32'({6'd24, 5'd10, 1'b1}));
        check({tag, "_poison"},
              32'({bus.poison_x, bus.poison_y,
                   bus.poison_valid}),
              32'({6'd10, 5'd20, 1'b1}));
        check({tag, "_flags"},
              32'({bus.add_cube, bus.hit_poison, bus.busy}), 0);
    endtask

    initial begin
        int e;
        int busy_low;
        int hx, hy;
        bit t, r;
        bus.tick = 0;
        bus.head_x = '0;
        bus.head_y = '0;

        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        check_reset_vals("rst");

        n_add = 0; a_rise = -1;
        cycle(0, 24, 10, 1);
        e = cyc;
        check("add_pulse", 32'(bus.add_cube), 1);
        check("apple_gone", 32'(bus.apple_valid), 0);
        for (int i = 0; i < 99; i++) cycle(0, 24, 10, 1);
        check("add_once", n_add, 1);
        check("apple_lat",
              32'(a_rise >= e + 2 && a_rise - e <= 32), 1);

        n_add = 0; n_hit = 0;
        cycle(0, 10, 20, 1);
        check("hit_pulse", 32'(bus.hit_poison), 1);
        for (int i = 0; i < 39; i++) cycle(0, 10, 20, 1);
        check("hit_once", n_hit, 1);
        check("hit_no_add", n_add, 0);

        n_hit = 0;
        for (int i = 0; i < LIFE; i++) begin
            cycle(1, 0, 0, 1);
            if (i < LIFE - 1)
                check("pois_alive", 32'(bus.poison_valid), 1);
            cycle(0, 0, 0, 1);
        end
        check("pois_expired", 32'(bus.poison_valid), 0);
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1);
        check("expire_no_hit", n_hit, 0);
        check("pois_back", 32'(bus.poison_valid), 1);

        for (int i = 0; i < LIFE - 1; i++) begin
            cycle(1, 0, 0, 1);
            cycle(0, 0, 0, 1);
        end
        n_add = 0; n_hit = 0; a_rise = -1; p_rise = -1;
        busy_low = 0;
        hx = int'(m_ax); hy = int'(m_ay);
        cycle(1, hx, hy, 1);
        for (int i = 0; i < 60; i++) begin
            cycle(0, hx, hy, 1);
            if (p_rise < 0 && !bus.busy) busy_low++;
        end
        check("sim_add_once", n_add, 1);
        check("sim_no_hit", n_hit, 0);
        check("sim_order", 32'(a_rise > 0 && p_rise > a_rise), 1);
        check("sim_busy", busy_low, 0);
        check("sim_distinct",
              32'({bus.apple_x, bus.apple_y} !=
                  {bus.poison_x, bus.poison_y}), 1);

        hx = int'(m_ax); hy = int'(m_ay);
        cycle(0, hx, hy, 1);
        check("mid_busy", 32'(bus.busy), 1);
        cycle(0, hx, hy, 0);
        check_reset_vals("midrst");
        n_add = 0; n_hit = 0;
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
        check("midrst_pulses", n_add + n_hit, 0);

        n_add = 0;
        for (int i = 0; i < 40000; i++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 5 && m_av) begin
                hx = int'(m_ax); hy = int'(m_ay);
            end else if (pick < 6 && m_pv) begin
                hx = int'(m_px); hy = int'(m_py);
            end else begin
                hx = $urandom_range(0, 63);
                hy = $urandom_range(0, 31);
            end
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 1999) != 0);
            cycle(t, hx, hy, r);
        end
        $display("random phase apple eats: %0d", n_add);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/item_spawner.md
# item_spawner

Parametrised food/hazard placement engine for the Snake game. It tracks one apple and one poison item on a configurable grid. It detects when the snake head lands on either item and emits single-cycle event pulses. It re-places eaten or expired items using LFSR rejection sampling that excludes the border, the head cell and the other item. It sits between the snake movement controller (head position, move tick) and the VGA renderer/score logic (item coordinates, event pulses).

## Interface
- GRID_W, 40, grid width in cells
- GRID_H, 30, grid height in cells
- X_W, 6, x coordinate width; 2^X_W >= GRID_W
- Y_W, 5, y coordinate width; 2^Y_W >= GRID_H
- BORDER, 1, wall thickness in cells; items never placed inside it
- SEED, 16'hACE1, LFSR reset value; must be non-zero
- POISON_LIFE, 256, move ticks before poison relocates; 0 disables expiry
- APPLE0_X / APPLE0_Y, 24 / 10, apple position after reset
- POISON0_X / POISON0_Y, 10 / 20, poison position after reset

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle strobe per snake move step
- head_x  in  X_W  snake head x
- head_y  in  Y_W  snake head y
- apple_x / apple_y  out  X_W / Y_W  apple position, registered
- apple_valid  out  1  apple present on grid
- poison_x / poison_y  out  X_W / Y_W  poison position, registered
- poison_valid  out  1  poison present on grid
- add_cube  out  1  one-cycle pulse: apple eaten
- hit_poison  out  1  one-cycle pulse: poison eaten
- busy  out  1  high while any respawn is pending or in progress

## Operation
- LFSR: 16-bit Galois, polynomial mask 16'hB400. It shifts every clock. The state is reloaded with SEED on reset.
- Candidate: cand_x = lfsr[X_W-1:0], cand_y = lfsr[15:16-Y_W].
- A candidate is accepted iff all of the following hold:
  - BORDER <= cand_x <= GRID_W-1-BORDER
  - BORDER <= cand_y <= GRID_H-1-BORDER
  - the candidate is not equal to (head_x, head_y)
  - the candidate is not equal to the other item's position when that item is valid
- Rejected candidates retry on the next clock. There is no retry cap; with the defaults the acceptance probability is above 0.5 per cycle.
- Eat detection is evaluated in IDLE every cycle:
  - apple_valid and head == apple: add_cube <= 1, apple_valid <= 0, apple_pend <= 1.
  - poison_valid and head == poison: hit_poison <= 1, poison_valid <= 0, poison_pend <= 1.
- Poison expiry:
  - life counter loads POISON_LIFE on reset and on every poison placement.
  - It decrements on tick while poison_valid.
  - A tick with counter == 1 sets poison_valid <= 0 and poison_pend <= 1. There is no hit_poison pulse for expiry.
- FSM states: IDLE, SPAWN_APPLE, SPAWN_POISON.
  - IDLE -> SPAWN_APPLE if apple_pend, else -> SPAWN_POISON if poison_pend. Apple has priority.
  - SPAWN_x: on accept, write the candidate to x_pos, set x_valid <= 1, clear x_pend, return to IDLE. Otherwise stay.
- Invalid items hold their last coordinates.
- Event detection for the other, still-valid item continues during SPAWN states. Expiry counting also continues.
- busy = apple_pend | poison_pend | (state != IDLE).

## Timing
- Reset values:
  - apple = (APPLE0_X, APPLE0_Y), apple_valid = 1
  - poison = (POISON0_X, POISON0_Y), poison_valid = 1
  - add_cube = 0, hit_poison = 0, busy = 0
  - state = IDLE, pend flags = 0, life = POISON_LIFE
- Head matches apple in cycle N: add_cube and apple_valid = 0 are visible in cycle N+1. add_cube lasts exactly one cycle.
- Earliest new apple: valid in N+3 (pend set N+1, SPAWN_APPLE N+2, accept N+2). Each rejection adds 1 cycle.
- A head held on the item for many cycles gives one pulse only, because detection is gated by valid. The new item excludes the head cell.
- Eat and expiry in the same cycle: both pend flags set; apple is respawned first, then poison.
- Poison hit on the same cycle as the final tick: hit_poison pulses once, one respawn.
- rst_n low mid-spawn: next clock returns all state to reset values. Pending respawns are discarded.

## Test plan
- Reset: hold rst_n low 10 cycles -> apple (24,10) valid, poison (10,20) valid, pulses 0, busy 0.
- Apple eat: head = (24,10) -> add_cube single pulse, apple_valid 0 next cycle. New apple valid within 32 cycles with x in [1,38], y in [1,28], not (24,10), not (10,20). Head held 100 cycles -> no second pulse.
- Poison hit: head = (10,20) -> hit_poison single pulse, add_cube stays 0. New poison in range and distinct from apple and head.
- Expiry (POISON_LIFE = 4): 4 ticks with head away from items -> poison_valid drops after the 4th tick, no hit_poison. Respawn lands at a new legal cell and the counter reloads.
- Simultaneous: head onto apple in the same cycle as the 4th tick -> add_cube once. Apple re-placed before poison, busy high throughout, final positions distinct.
- Reset mid-spawn: assert rst_n low while busy = 1 -> reset values next cycle, no pulses afterwards.
- 10,000 random eats: the legality checks above hold every time.
